// File: rtl/GamePkg.sv
// Shared game-side types plus the LAN frame constants and transmitter state encoding.
package GamePkg;

  localparam int PLAYFIELD_ROWS    = 20;
  localparam int PLAYFIELD_COLS    = 10;
  localparam int NEXT_PIECES_COUNT = 5;

  typedef enum logic [3:0] {
    TILE_BLANK   = 4'd0,
    TILE_I       = 4'd1,
    TILE_O       = 4'd2,
    TILE_T       = 4'd3,
    TILE_S       = 4'd4,
    TILE_Z       = 4'd5,
    TILE_J       = 4'd6,
    TILE_L       = 4'd7,
    TILE_GARBAGE = 4'd8
  } tile_type_t;

  localparam logic [7:0] LAN_SYNC_BYTE   = 8'hA5;
  localparam int         LAN_FRAME_BYTES = 103 + NEXT_PIECES_COUNT;

  // Two tiles per field byte: even column in the low nibble, odd column in the high nibble.
  localparam int FIELD_PAIRS     = PLAYFIELD_COLS / 2;
  localparam int LAN_FIELD_BYTES = PLAYFIELD_ROWS * FIELD_PAIRS;

  localparam int ROW_W  = $clog2(PLAYFIELD_ROWS);
  localparam int COL_W  = $clog2(PLAYFIELD_COLS);
  localparam int PAIR_W = $clog2(FIELD_PAIRS);
  localparam int QPTR_W = $clog2(NEXT_PIECES_COUNT);
  localparam int FPTR_W = $clog2(LAN_FIELD_BYTES);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC,
    TX_HOLD,
    TX_NEXT,
    TX_FIELD,
    TX_CHECK
  } tx_state_t;

endpackage

// File: rtl/game_state_transmitter.sv
// Serialises a snapshot of the local game state into one framed, checksummed byte
// stream over a valid/ready link: sync, hold, next queue, packed field, XOR checksum.
module game_state_transmitter
  import GamePkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = LAN_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       send_start,
  input  tile_type_t playfield_data [PLAYFIELD_ROWS][PLAYFIELD_COLS],
  input  tile_type_t next_pieces_queue [NEXT_PIECES_COUNT],
  input  tile_type_t hold_piece_type,
  input  logic       hold_piece_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [QPTR_W-1:0] QPTR_LAST = QPTR_W'(NEXT_PIECES_COUNT - 1);
  localparam logic [FPTR_W-1:0] FPTR_LAST = FPTR_W'(LAN_FIELD_BYTES - 1);

  tx_state_t         state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        csum_q, csum_d;
  logic [QPTR_W-1:0] qptr_q, qptr_d;
  logic [FPTR_W-1:0] fptr_q, fptr_d;
  logic              snap_en;

  tile_type_t field_snap [PLAYFIELD_ROWS][PLAYFIELD_COLS];
  tile_type_t queue_snap [NEXT_PIECES_COUNT];
  tile_type_t hold_type_snap;
  logic       hold_valid_snap;

  logic              handshake;
  logic [QPTR_W-1:0] q_sel;
  logic [FPTR_W-1:0] f_sel;
  logic [ROW_W-1:0]  f_row;
  logic [PAIR_W-1:0] f_pair;
  logic [COL_W-1:0]  col_lo, col_hi;
  logic [7:0]        hold_byte, queue_byte, field_byte;

  assign handshake = tx_valid_q && tx_ready;

  // Operand fetch: each selector points at the byte that follows the one on the link now.
  always_comb begin
    q_sel = (state_q == TX_NEXT  && qptr_q != QPTR_LAST) ? qptr_q + QPTR_W'(1) : '0;
    f_sel = (state_q == TX_FIELD && fptr_q != FPTR_LAST) ? fptr_q + FPTR_W'(1) : '0;
    f_row  = ROW_W'(f_sel / FPTR_W'(FIELD_PAIRS));
    f_pair = PAIR_W'(f_sel % FPTR_W'(FIELD_PAIRS));
    col_lo = COL_W'({f_pair, 1'b0});
    col_hi = COL_W'({f_pair, 1'b1});
    hold_byte  = {hold_valid_snap, 3'b000, hold_type_snap};
    queue_byte = {4'b0000, queue_snap[q_sel]};
    field_byte = {field_snap[f_row][col_hi], field_snap[f_row][col_lo]};
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    csum_d       = csum_q;
    qptr_d       = qptr_q;
    fptr_d       = fptr_q;
    snap_en      = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        if (send_start) begin
          snap_en    = 1'b1;
          state_d    = TX_SYNC;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          csum_d     = '0;
          qptr_d     = '0;
          fptr_d     = '0;
        end
      end
      TX_SYNC: begin
        if (handshake) begin
          state_d   = TX_HOLD;
          tx_data_d = hold_byte;
        end
      end
      TX_HOLD: begin
        if (handshake) begin
          csum_d    = csum_q ^ tx_data_q;
          state_d   = TX_NEXT;
          qptr_d    = '0;
          tx_data_d = queue_byte;
        end
      end
      TX_NEXT: begin
        if (handshake) begin
          csum_d = csum_q ^ tx_data_q;
          if (qptr_q == QPTR_LAST) begin
            state_d   = TX_FIELD;
            fptr_d    = '0;
            tx_data_d = field_byte;
          end else begin
            qptr_d    = qptr_q + QPTR_W'(1);
            tx_data_d = queue_byte;
          end
        end
      end
      TX_FIELD: begin
        if (handshake) begin
          csum_d = csum_q ^ tx_data_q;
          if (fptr_q == FPTR_LAST) begin
            state_d   = TX_CHECK;
            tx_data_d = csum_d;
          end else begin
            fptr_d    = fptr_q + FPTR_W'(1);
            tx_data_d = field_byte;
          end
        end
      end
      TX_CHECK: begin
        if (handshake) begin
          state_d      = TX_IDLE;
          tx_data_d    = '0;
          tx_valid_d   = 1'b0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= TX_IDLE;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      csum_q       <= '0;
      qptr_q       <= '0;
      fptr_q       <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      csum_q       <= csum_d;
      qptr_q       <= qptr_d;
      fptr_q       <= fptr_d;
    end
  end

  // NOTE: the snapshot is a plain data store with no reset; it is always loaded before it is read.
  always_ff @(posedge clk) begin
    if (snap_en) begin
      field_snap      <= playfield_data;
      queue_snap      <= next_pieces_queue;
      hold_type_snap  <= hold_piece_type;
      hold_valid_snap <= hold_piece_valid;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_game_state_transmitter.sv
// Randomised bench for game_state_transmitter against a frame-level reference model.
module tb_game_state_transmitter;
  import GamePkg::*;

  logic       clk;
  logic       rst_l;
  logic       send_start;
  tile_type_t pf [PLAYFIELD_ROWS][PLAYFIELD_COLS];
  tile_type_t nq [NEXT_PIECES_COUNT];
  tile_type_t hold_type;
  logic       hold_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;

  int n_vectors;
  int n_miscompares;

  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  game_state_transmitter dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .send_start        (send_start),
    .playfield_data    (pf),
    .next_pieces_queue (nq),
    .hold_piece_type   (hold_type),
    .hold_piece_valid  (hold_valid),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int r = 0; r < PLAYFIELD_ROWS; r++)
      for (int c = 0; c < PLAYFIELD_COLS; c++) pf[r][c] = TILE_BLANK;
    for (int i = 0; i < NEXT_PIECES_COUNT; i++) nq[i] = TILE_BLANK;
    hold_type  = TILE_BLANK;
    hold_valid = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int r = 0; r < PLAYFIELD_ROWS; r++)
      for (int c = 0; c < PLAYFIELD_COLS; c++) pf[r][c] = tile_type_t'($urandom_range(8));
    for (int i = 0; i < NEXT_PIECES_COUNT; i++) nq[i] = tile_type_t'($urandom_range(8));
    hold_type  = tile_type_t'($urandom_range(8));
    hold_valid = 1'($urandom_range(1));
  endtask

  // Reference frame built straight from the byte-layout rules.
  task automatic build_expected();
    logic [7:0] b;
    logic [7:0] sum;
    exp_q.delete();
    sum = 8'h00;
    exp_q.push_back(8'hA5);
    b = {hold_valid, 3'b000, hold_type};
    exp_q.push_back(b);
    sum ^= b;
    for (int i = 0; i < NEXT_PIECES_COUNT; i++) begin
      b = {4'b0000, nq[i]};
      exp_q.push_back(b);
      sum ^= b;
    end
    for (int r = 0; r < PLAYFIELD_ROWS; r++)
      for (int c = 0; c < PLAYFIELD_COLS; c += 2) begin
        b = {pf[r][c+1], pf[r][c]};
        exp_q.push_back(b);
        sum ^= b;
      end
    exp_q.push_back(sum);
  endtask

  // Requests one frame (caller sits just after a falling edge with the DUT idle),
  // collects accepted bytes and checks timing, stall stability and content.
  task automatic do_frame(input int ready_pct, input bit keep_start, input bit disturb);
    int         cycles, last_push, gaps, n;
    bit         done, stall_prev;
    logic [7:0] prev_data;
    build_expected();
    got_q.delete();
    cycles = 0; last_push = -100; gaps = 0; done = 0; stall_prev = 0; prev_data = '0;
    send_start = 1'b1;
    while (!done && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      if (!keep_start) send_start = 1'b0;
      if (cycles == 1) check("start_latency", 32'(tx_valid), 32'd1);
      if (stall_prev) begin
        check("stall_data", 32'(tx_data), 32'(prev_data));
        check("stall_valid", 32'(tx_valid), 32'd1);
      end
      if (frame_done) begin
        done = 1;
        check("done_timing", 32'(cycles - last_push), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_valid", 32'(tx_valid), 32'd0);
      end else begin
        if (!tx_valid) gaps++;
        tx_ready = ($urandom_range(99) < ready_pct);
        if (tx_valid && tx_ready) begin
          got_q.push_back(tx_data);
          last_push = cycles;
        end
        stall_prev = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (disturb && cycles == 30) begin
          rand_inputs();
          send_start = 1'b1;
        end
      end
    end
    if (!done) check("frame_timeout", 32'd0, 32'd1);
    check("frame_len", 32'(got_q.size()), 32'(LAN_FRAME_BYTES));
    check("valid_gaps", 32'(gaps), 32'd0);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic expect_idle(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy || tx_valid) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int cnt, cyc;
    n_vectors     = 0;
    n_miscompares = 0;
    rst_l      = 1'b0;
    send_start = 1'b0;
    tx_ready   = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst_l = 1'b1;
    @(negedge clk);
    expect_idle("idle_after_reset", 3);

    // Blank field and queue, hold T valid, link always ready.
    clear_inputs();
    hold_type  = TILE_T;
    hold_valid = 1'b1;
    do_frame(100, 0, 0);
    if (got_q.size() == LAN_FRAME_BYTES) begin
      check("t1_sync", 32'(got_q[0]), 32'h000000A5);
      check("t1_hold", 32'(got_q[1]), 32'h00000083);
      check("t1_csum", 32'(got_q[LAN_FRAME_BYTES-1]), 32'h00000083);
    end else check("t1_size", 32'(got_q.size()), 32'(LAN_FRAME_BYTES));

    // Corner tiles land in the right nibbles.
    clear_inputs();
    pf[0][0]  = TILE_I;
    pf[0][1]  = TILE_O;
    pf[19][9] = TILE_Z;
    @(negedge clk);
    do_frame(100, 0, 0);
    if (got_q.size() == LAN_FRAME_BYTES) begin
      check("t2_first_field", 32'(got_q[2+NEXT_PIECES_COUNT]), 32'h00000021);
      check("t2_last_field_hi", 32'(got_q[LAN_FRAME_BYTES-2][7:4]), 32'h5);
    end else check("t2_size", 32'(got_q.size()), 32'(LAN_FRAME_BYTES));

    // Random content under 50% back-pressure.
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      @(negedge clk);
      do_frame(50, 0, 0);
    end

    // Inputs changed and send_start pulsed mid-frame.
    rand_inputs();
    @(negedge clk);
    do_frame(70, 0, 1);
    expect_idle("no_second_frame", 6);

    // Reset in the middle of a frame, then a clean frame.
    rand_inputs();
    send_start = 1'b1;
    cnt = 0;
    cyc = 0;
    while (cnt < 40 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      send_start = 1'b0;
      tx_ready = 1'($urandom_range(1));
      if (tx_valid && tx_ready) cnt++;
    end
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_l    = 1'b0;
    tx_ready = 1'b0;
    #1;
    check("midrst_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(tx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    expect_idle("idle_after_midrst", 3);
    rand_inputs();
    do_frame(100, 0, 0);

    // send_start held high: frames back to back with a single idle cycle between.
    rand_inputs();
    @(negedge clk);
    do_frame(100, 1, 0);
    rand_inputs();
    do_frame(100, 1, 0);
    rand_inputs();
    do_frame(100, 0, 0);
    expect_idle("idle_after_b2b", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/game_state_transmitter.md
GAME_STATE_TRANSMITTER -- requirements
Module: game_state_transmitter

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the first byte of every frame.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_l  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port send_start  input  1  request one frame; sampled only when busy=0.
REQ-005 SHALL have port playfield_data  input  tile_type_t[PLAYFIELD_ROWS][PLAYFIELD_COLS]  local playfield.
REQ-006 SHALL have port next_pieces_queue  input  tile_type_t[NEXT_PIECES_COUNT]  local next queue.
REQ-007 SHALL have port hold_piece_type  input  tile_type_t  local hold piece.
REQ-008 SHALL have port hold_piece_valid  input  1  hold slot occupied.
REQ-009 SHALL have port tx_data  output  8  current frame byte.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid.
REQ-011 SHALL have port tx_ready  input  1  downstream link accepts the byte when tx_valid&&tx_ready.
REQ-012 SHALL have port busy  output  1  frame in progress.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 SHALL use states IDLE, SYNC, HOLD, NEXT, FIELD, CHECK.
REQ-015 SHALL, in IDLE with send_start=1 at edge t, snapshot playfield, queue, hold type and valid, enter SYNC, and drive tx_valid=1 from cycle t+1.
REQ-016 SHALL ignore send_start whenever busy=1, with no effect on the snapshot or the frame.
REQ-017 SHALL transmit frame order: SYNC_BYTE; hold byte; NEXT_PIECES_COUNT queue bytes, index 0 first; 100 field bytes; checksum byte.
REQ-018 SHALL make each frame exactly 103+NEXT_PIECES_COUNT bytes long.
REQ-019 SHALL form the hold byte as {hold_valid, 3'b0, hold_type[3:0]}.
REQ-020 SHALL form each queue byte as {4'b0, tile[3:0]}.
REQ-021 SHALL send field bytes row 0..19, column pairs (0,1)..(8,9), with the even column in [3:0] and the odd column in [7:4].
REQ-022 SHALL make the checksum the XOR of all bytes from the hold byte through the last field byte.
REQ-023 SHALL advance the byte pointer only on a tx_valid&&tx_ready handshake.
REQ-024 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-025 SHALL keep tx_valid at 1 continuously from SYNC through CHECK, with no bubbles when tx_ready=1.
REQ-026 SHALL, on the CHECK handshake, pulse frame_done for the next cycle, return to IDLE, and drive busy=0 and tx_valid=0 in that cycle.
REQ-027 SHALL assert busy in every state except IDLE.
REQ-028 SHALL accept the next send_start no earlier than the cycle frame_done is high.
REQ-029 SHALL NOT alter the frame in progress when inputs change during it; only the snapshot is transmitted.
REQ-030 SHALL use a field pointer that stops at 99 and never wraps within a frame.

Reset
REQ-031 SHALL, when rst_l=0 at any time including mid-frame, immediately force IDLE, tx_valid=0, tx_data=0, busy=0, frame_done=0, checksum=0, and pointers=0.
REQ-032 SHALL leave the snapshot registers undefined-don't-care after reset.
REQ-033 SHALL start the first frame after reset release only on a fresh send_start.

Structure
REQ-034 SHALL take tile_type_t (4-bit encoding), PLAYFIELD_ROWS, PLAYFIELD_COLS and NEXT_PIECES_COUNT from GamePkg.
REQ-035 SHALL add to GamePkg: LAN_SYNC_BYTE, LAN_FRAME_BYTES (=103+NEXT_PIECES_COUNT), and the tx state enum.
REQ-036 SHALL implement the logic as a single module; the checksum accumulator and nibble packer are inline, and no sub-module is required.

Verification
REQ-037 SHALL test: all-BLANK field, hold T valid, tx_ready=1 -> contiguous frame of LAN_FRAME_BYTES bytes, byte0=8'hA5, byte1={1,000,T}, checksum matches a model, frame_done one cycle after the last byte.
REQ-038 SHALL test: field[0][0]=I, field[0][1]=O, field[19][9]=Z -> field byte 0 = {O,I}, last field byte high nibble = Z.
REQ-039 SHALL test: tx_ready toggled randomly 50% -> identical byte sequence, and tx_data stable across every stalled cycle.
REQ-040 SHALL test: inputs changed and send_start pulsed mid-frame -> frame equals the snapshot and no second frame starts.
REQ-041 SHALL test: rst_l low at byte 40 -> tx_valid=0 and busy=0 immediately; a new send_start yields a complete, correct frame.
REQ-042 SHALL test: send_start held high continuously -> back-to-back frames, each starting with 8'hA5, separated by the single IDLE cycle.
